// File: rtl/pwm_dc_ramp_pkg.sv
// Shared constants for the PWM duty-cycle ramp sequencer: register map,
// state encoding and CTRL bit positions.
package pwm_dc_ramp_pkg;

   localparam logic [7:0] ADR_CTRL     = 8'h00;
   localparam logic [7:0] ADR_MIN      = 8'h04;
   localparam logic [7:0] ADR_MAX      = 8'h08;
   localparam logic [7:0] ADR_STEP     = 8'h0C;
   localparam logic [7:0] ADR_INTERVAL = 8'h10;
   localparam logic [7:0] ADR_STATUS   = 8'h14;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_MODE = 1;
   localparam int unsigned CTRL_IRQ  = 2;

endpackage

// File: rtl/pwm_interval_timer.sv
// Step-interval timer: counts while enabled and emits a one-cycle step pulse
// every interval_i+1 enabled cycles.
module pwm_interval_timer #(
   parameter int unsigned TW = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [TW-1:0] interval_i,
   output logic          step_o
);

   logic [TW-1:0] cnt_q, cnt_d;
   logic          hit;

   always_comb begin
      // >= so that lowering the interval mid-count steps at once instead of wrapping
      hit    = (cnt_q >= interval_i);
      step_o = en_i & ~clr_i & hit;
      cnt_d  = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = hit ? '0 : cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_dc_ramp.sv
// Duty-cycle ramp sequencer feeding the PWM i_DC/i_valid_DC inputs with
// saturating one-shot or triangle ramps, programmed over the register bus.
module pwm_dc_ramp
   import pwm_dc_ramp_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned TW = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          re_i,
   input  logic          we_i,
   input  logic [7:0]    addr_i,
   input  logic [31:0]   wdata_i,
   input  logic [3:0]    be_i,
   output logic [31:0]   rdata_o,
   output logic          error_o,
   output logic [DW-1:0] o_DC,
   output logic          o_valid_DC,
   output logic          o_irq
);

   logic          en_q, en_d, mode_q, mode_d;
   logic [DW-1:0] min_q, min_d, max_q, max_d, step_q, step_d;
   logic [TW-1:0] interval_q, interval_d;
   logic [1:0]    state_q, state_d;
   logic [DW-1:0] dc_q, dc_d;
   logic          valid_q, valid_d, irq_q, irq_d, cfg_err_q, cfg_err_d;

   logic          unmapped, wr, wr_ctrl, start_req, stop_req;
   logic          tick_clr, tick_en, step_pulse;
   logic [DW-1:0] step_eff, up_val, dn_val;
   logic [DW:0]   up_sum, dn_diff;
   logic          unused_in;

   assign unused_in = ^{be_i, wdata_i};

   always_comb begin
      unmapped = 1'b1;
      rdata_o  = '0;
      case (addr_i)
         ADR_CTRL: begin
            unmapped           = 1'b0;
            rdata_o[CTRL_EN]   = en_q;
            rdata_o[CTRL_MODE] = mode_q;
            rdata_o[CTRL_IRQ]  = irq_q;
         end
         ADR_MIN: begin
            unmapped          = 1'b0;
            rdata_o[DW-1:0]   = min_q;
         end
         ADR_MAX: begin
            unmapped          = 1'b0;
            rdata_o[DW-1:0]   = max_q;
         end
         ADR_STEP: begin
            unmapped          = 1'b0;
            rdata_o[DW-1:0]   = step_q;
         end
         ADR_INTERVAL: begin
            unmapped          = 1'b0;
            rdata_o[TW-1:0]   = interval_q;
         end
         ADR_STATUS: begin
            unmapped          = 1'b0;
            rdata_o[15:0]     = 16'(dc_q);
            rdata_o[17:16]    = state_q;
            rdata_o[18]       = cfg_err_q;
         end
         default: unmapped = 1'b1;
      endcase
   end

   assign error_o   = (re_i | we_i) & (unmapped | (re_i & we_i));
   assign wr        = we_i & ~re_i & ~error_o;
   assign wr_ctrl   = wr & (addr_i == ADR_CTRL);
   assign start_req = wr_ctrl & wdata_i[CTRL_EN] & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign stop_req  = wr_ctrl & ~wdata_i[CTRL_EN];
   assign tick_clr  = start_req | stop_req;
   assign tick_en   = (state_q == ST_UP) | (state_q == ST_DOWN);

   pwm_interval_timer #(
      .TW(TW)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (tick_clr),
      .en_i       (tick_en),
      .interval_i (interval_q),
      .step_o     (step_pulse)
   );

   // Widened by one bit so both directions saturate instead of wrapping
   always_comb begin
      step_eff = (step_q == '0) ? DW'(1) : step_q;
      up_sum   = {1'b0, dc_q} + {1'b0, step_eff};
      dn_diff  = {1'b0, dc_q} - {1'b0, step_eff};
      up_val   = (up_sum > {1'b0, max_q}) ? max_q : up_sum[DW-1:0];
      dn_val   = (dn_diff[DW] || (dn_diff[DW-1:0] < min_q)) ? min_q : dn_diff[DW-1:0];
   end

   always_comb begin
      en_d       = en_q;
      mode_d     = mode_q;
      min_d      = min_q;
      max_d      = max_q;
      step_d     = step_q;
      interval_d = interval_q;
      state_d    = state_q;
      dc_d       = dc_q;
      valid_d    = 1'b0;
      irq_d      = irq_q;
      cfg_err_d  = cfg_err_q;

      if (wr) begin
         case (addr_i)
            ADR_CTRL: begin
               en_d   = wdata_i[CTRL_EN];
               mode_d = wdata_i[CTRL_MODE];
               if (wdata_i[CTRL_IRQ]) irq_d = 1'b0;
            end
            ADR_MIN:      min_d      = wdata_i[DW-1:0];
            ADR_MAX:      max_d      = wdata_i[DW-1:0];
            ADR_STEP:     step_d     = wdata_i[DW-1:0];
            ADR_INTERVAL: interval_d = wdata_i[TW-1:0];
            default: ;
         endcase
      end

      if (stop_req) begin
         state_d = ST_IDLE;
      end else if (start_req) begin
         if (min_q <= max_q) begin
            dc_d      = min_q;
            valid_d   = 1'b1;
            state_d   = ST_UP;
            cfg_err_d = 1'b0;
         end else begin
            state_d   = ST_IDLE;
            cfg_err_d = 1'b1;
         end
      end else if (step_pulse) begin
         case (state_q)
            ST_UP: begin
               dc_d    = up_val;
               valid_d = 1'b1;
               if (up_val == max_q) begin
                  state_d = mode_q ? ST_DOWN : ST_DONE;
                  if (!mode_q) irq_d = 1'b1;
               end
            end
            ST_DOWN: begin
               dc_d    = dn_val;
               valid_d = 1'b1;
               if (dn_val == min_q) state_d = ST_UP;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q       <= 1'b0;
         mode_q     <= 1'b0;
         min_q      <= '0;
         max_q      <= '0;
         step_q     <= '0;
         interval_q <= '0;
         state_q    <= ST_IDLE;
         dc_q       <= '0;
         valid_q    <= 1'b0;
         irq_q      <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         en_q       <= en_d;
         mode_q     <= mode_d;
         min_q      <= min_d;
         max_q      <= max_d;
         step_q     <= step_d;
         interval_q <= interval_d;
         state_q    <= state_d;
         dc_q       <= dc_d;
         valid_q    <= valid_d;
         irq_q      <= irq_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign o_DC       = dc_q;
   assign o_valid_DC = valid_q;
   assign o_irq      = irq_q;

endmodule
